// File: rtl/regincr_out_queue.sv
// regincr_out_queue
//   Output queue for the registered incrementer: a p_depth-entry FIFO with
//   valid/ready handshakes on both sides and a saturating counter of rejected
//   enqueue attempts.
//
// Ports
//   clk      in   single clock, all state updates on the rising edge
//   reset    in   asynchronous active-high reset
//   enq_val  in   upstream presents valid data
//   enq_rdy  out  queue can accept data this cycle (not full)
//   enq_msg  in   enqueue data, p_nbits wide
//   deq_val  out  head entry is valid (not empty)
//   deq_rdy  in   downstream accepts the head entry
//   deq_msg  out  head entry, don't-care while deq_val=0
//   count    out  current occupancy, clog2(p_depth)+1 bits
//   ovf_cnt  out  saturating count of cycles with enq_val=1 and enq_rdy=0
module regincr_out_queue #(
    parameter int unsigned p_nbits = 8,
    parameter int unsigned p_depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [p_nbits-1:0]         enq_msg,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [p_nbits-1:0]         deq_msg,
    output logic [$clog2(p_depth):0]   count,
    output logic [7:0]                 ovf_cnt
);

    localparam int unsigned AW = $clog2(p_depth);
    localparam int unsigned CW = AW + 1;

    logic [p_nbits-1:0] mem_q [p_depth];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    ovf_q, ovf_d;

    logic enq_fire;
    logic deq_fire;

    // Ready does not look at deq_rdy: a full queue never takes data in the
    // same cycle it drains, and an empty queue has no bypass path.
    assign enq_rdy = (count_q != CW'(p_depth));
    assign deq_val = (count_q != CW'(0));
    assign deq_msg = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign ovf_cnt = ovf_q;

    // Gating with reset keeps the storage write from firing on a reset edge.
    assign enq_fire = enq_val && enq_rdy && !reset;
    assign deq_fire = deq_val && deq_rdy && !reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (enq_fire) begin
            wr_ptr_d = (wr_ptr_q == AW'(p_depth - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = (rd_ptr_q == AW'(p_depth - 1)) ? '0 : rd_ptr_q + AW'(1);
        end

        if (enq_fire && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CW'(1);
        end

        if (enq_val && !enq_rdy && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q] <= enq_msg;
        end
    end

endmodule

// File: tb/tb_regincr_out_queue.sv
// tb_regincr_out_queue
//   Directed bench for regincr_out_queue with default parameters
//   (8-bit data, 4 entries). Inputs change 1 time unit after a rising edge,
//   outputs are checked at that same point, well away from the next edge.
module tb_regincr_out_queue;

    logic       clk;
    logic       reset;
    logic       enq_val;
    logic       enq_rdy;
    logic [7:0] enq_msg;
    logic       deq_val;
    logic       deq_rdy;
    logic [7:0] deq_msg;
    logic [2:0] count;
    logic [7:0] ovf_cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    regincr_out_queue #(
        .p_nbits (8),
        .p_depth (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enq_val (enq_val),
        .enq_rdy (enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .count   (count),
        .ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_seq [6];
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enq_val  = 1'b0;
        enq_msg  = 8'h00;
        deq_rdy  = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_count",   32'(count),   32'd0);
        check("rst_deq_val", 32'(deq_val), 32'd0);
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("rst_ovf",     32'(ovf_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Three back-to-back enqueues, no dequeue
        enq_val = 1'b1;
        enq_msg = 8'h05;
        check("t1_deq_val_pre", 32'(deq_val), 32'd0);
        tick();
        check("t1_count1",   32'(count),   32'd1);
        check("t1_deq_val1", 32'(deq_val), 32'd1);
        check("t1_head1",    32'(deq_msg), 32'h05);
        enq_msg = 8'h06;
        tick();
        check("t1_count2", 32'(count),   32'd2);
        check("t1_head2",  32'(deq_msg), 32'h05);
        enq_msg = 8'h07;
        tick();
        check("t1_count3", 32'(count),   32'd3);
        check("t1_head3",  32'(deq_msg), 32'h05);
        enq_val = 1'b0;
        deq_rdy = 1'b1;
        tick();
        check("t1_drain_c2", 32'(count),   32'd2);
        check("t1_drain_h6", 32'(deq_msg), 32'h06);
        tick();
        check("t1_drain_c1", 32'(count),   32'd1);
        check("t1_drain_h7", 32'(deq_msg), 32'h07);
        tick();
        check("t1_drain_c0", 32'(count),   32'd0);
        check("t1_drain_dv", 32'(deq_val), 32'd0);
        deq_rdy = 1'b0;

        // Fill to full, then three rejected enqueues of 0x14
        enq_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_msg = 8'h10 + 8'(i);
            tick();
        end
        check("t2_count_full", 32'(count),   32'd4);
        check("t2_enq_rdy",    32'(enq_rdy), 32'd0);
        check("t2_ovf0",       32'(ovf_cnt), 32'd0);
        enq_msg = 8'h14;
        tick();
        check("t2_ovf1", 32'(ovf_cnt), 32'd1);
        tick();
        check("t2_ovf2", 32'(ovf_cnt), 32'd2);
        tick();
        check("t2_ovf3",       32'(ovf_cnt), 32'd3);
        check("t2_count_held", 32'(count),   32'd4);
        enq_val = 1'b0;
        tick();
        check("t2_ovf_hold", 32'(ovf_cnt), 32'd3);
        deq_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_head%0d", i), 32'(deq_msg), 32'h10 + 32'(i));
            tick();
        end
        check("t2_empty_count", 32'(count),   32'd0);
        check("t2_empty_dv",    32'(deq_val), 32'd0);
        deq_rdy = 1'b0;

        // Two entries queued, then six simultaneous enqueue/dequeue cycles
        enq_val = 1'b1;
        enq_msg = 8'hA0;
        tick();
        enq_msg = 8'hA1;
        tick();
        check("t3_count_pre", 32'(count), 32'd2);
        exp_seq[0] = 8'hA0;
        exp_seq[1] = 8'hA1;
        exp_seq[2] = 8'h20;
        exp_seq[3] = 8'h21;
        exp_seq[4] = 8'h22;
        exp_seq[5] = 8'h23;
        deq_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enq_msg = 8'h20 + 8'(i);
            check($sformatf("t3_head%0d", i), 32'(deq_msg), 32'(exp_seq[i]));
            tick();
            check($sformatf("t3_count%0d", i), 32'(count), 32'd2);
        end
        enq_val = 1'b0;
        check("t3_tail0", 32'(deq_msg), 32'h24);
        tick();
        check("t3_tail1", 32'(deq_msg), 32'h25);
        tick();
        check("t3_count_end", 32'(count), 32'd0);

        // Empty queue, enqueue with deq_rdy held: no bypass
        enq_val = 1'b1;
        enq_msg = 8'hFF;
        check("t4_dv_enq_cycle", 32'(deq_val), 32'd0);
        tick();
        enq_val = 1'b0;
        check("t4_dv_next",   32'(deq_val), 32'd1);
        check("t4_head_ff",   32'(deq_msg), 32'hFF);
        check("t4_count1",    32'(count),   32'd1);
        tick();
        check("t4_count0", 32'(count),   32'd0);
        check("t4_dv0",    32'(deq_val), 32'd0);
        deq_rdy = 1'b0;

        // Fill, then 300 rejected enqueues: ovf_cnt saturates (starts at 3)
        enq_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_msg = 8'h30 + 8'(i);
            tick();
        end
        check("t5_count_full", 32'(count), 32'd4);
        enq_msg = 8'h3F;
        repeat (251) tick();
        check("t5_ovf_254", 32'(ovf_cnt), 32'd254);
        tick();
        check("t5_ovf_255", 32'(ovf_cnt), 32'd255);
        repeat (48) tick();
        check("t5_ovf_sat",   32'(ovf_cnt), 32'd255);
        check("t5_count_held", 32'(count),  32'd4);
        check("t5_head",       32'(deq_msg), 32'h30);
        enq_val = 1'b0;

        // Asynchronous reset mid-cycle on a full queue
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t6_count",   32'(count),   32'd0);
        check("t6_deq_val", 32'(deq_val), 32'd0);
        check("t6_enq_rdy", 32'(enq_rdy), 32'd1);
        check("t6_ovf",     32'(ovf_cnt), 32'd0);
        // Enqueue request across a reset edge must not take effect
        enq_val = 1'b1;
        enq_msg = 8'h55;
        tick();
        check("t6_no_fire_count", 32'(count), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        enq_msg = 8'h42;
        tick();
        enq_val = 1'b0;
        check("t6_post_count", 32'(count),   32'd1);
        check("t6_post_head",  32'(deq_msg), 32'h42);
        deq_rdy = 1'b1;
        tick();
        check("t6_post_empty", 32'(count), 32'd0);
        deq_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regincr_out_queue.md
REGINCR_OUT_QUEUE -- requirements
Module: regincr_out_queue

Interface
REQ-001 The block SHALL have parameter p_nbits, default 8, giving the data width (matches incrementer out).
REQ-002 The block SHALL have parameter p_depth, default 4, giving the entry count; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port enq_val, input, 1, meaning upstream presents valid data.
REQ-006 The block SHALL have port enq_rdy, output, 1, meaning the queue can accept data this cycle.
REQ-007 The block SHALL have port enq_msg, input, p_nbits, carrying the enqueue data (driven by the incrementer out).
REQ-008 The block SHALL have port deq_val, output, 1, meaning head data is valid.
REQ-009 The block SHALL have port deq_rdy, input, 1, meaning downstream accepts head data.
REQ-010 The block SHALL have port deq_msg, output, p_nbits, carrying the head entry.
REQ-011 The block SHALL have port count, output, clog2(p_depth)+1, giving current occupancy.
REQ-012 The block SHALL have port ovf_cnt, output, 8, giving a saturating count of rejected enqueue attempts.

Function
REQ-013 Enqueue fire SHALL be enq_val && enq_rdy; dequeue fire SHALL be deq_val && deq_rdy.
REQ-014 enq_rdy SHALL be (count != p_depth), independent of deq_rdy; a full queue does not accept data in the same cycle as a dequeue.
REQ-015 deq_val SHALL be (count != 0); there is no enqueue-to-dequeue bypass.
REQ-016 Data enqueued at edge N SHALL be visible on deq_msg, with deq_val=1, in cycle N+1 at the earliest; minimum latency is 1 cycle.
REQ-017 deq_msg SHALL equal the storage entry at the read pointer; its value is don't-care when deq_val=0.
REQ-018 Entries SHALL dequeue in strict FIFO order with no loss or duplication.
REQ-019 The write and read pointers SHALL each advance by one on their respective fire events and wrap from p_depth-1 to 0.
REQ-020 count SHALL increment on enqueue-only, decrement on dequeue-only, and hold on simultaneous fire or when neither fires.
REQ-021 Simultaneous fire SHALL be legal whenever 0 < count < p_depth; both pointers advance and count is unchanged.
REQ-022 With count=0, only an enqueue can fire; a dequeue request is ignored.
REQ-023 With count=p_depth, only a dequeue can fire; enq_val=1 causes no write.
REQ-024 ovf_cnt SHALL increment by 1 on each cycle with enq_val=1 and enq_rdy=0, and saturate at 255.
REQ-025 Arithmetic on count, pointers and ovf_cnt SHALL be unsigned with explicitly sized operands; no state wraps except the pointers.

Reset
REQ-026 While reset=1, asynchronously and independent of clk: count=0, pointers=0, ovf_cnt=0, deq_val=0, enq_rdy=1.
REQ-027 Storage contents SHALL NOT require reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; the first enqueue after deassertion behaves as an enqueue into an empty queue.
REQ-029 No fire event SHALL occur on a rising edge where reset=1.

Verification
REQ-030 Reset, then enq 0x05, 0x06, 0x07 on consecutive cycles with deq_rdy=0 -> count 1,2,3; deq_val=1 from the cycle after the first enqueue; deq_msg=0x05.
REQ-031 Fill with 0x10..0x13, hold enq_val=1 with 0x14 for 3 cycles, deq_rdy=0 -> enq_rdy=0, count=4, ovf_cnt=3, and 0x14 is never stored.
REQ-032 count=2, enq_val=1 and deq_rdy=1 together for 6 cycles with data 0x20..0x25 -> count stays 2; dequeue sequence is the 2 prior entries then 0x20..0x23 (pointer wrap exercised).
REQ-033 Empty queue, enq 0xFF with deq_rdy=1 held -> deq_val=0 in the enqueue cycle; 0xFF dequeued the next cycle; count returns to 0.
REQ-034 Full queue, assert reset asynchronously mid-cycle -> count=0, deq_val=0, enq_rdy=1 and ovf_cnt=0 before the next clk edge.
REQ-035 Drive 300 rejected enqueue cycles on a full queue -> ovf_cnt stops at 255.
